// File: rtl/rst_seq_pkg.sv
// Shared types, defaults and sizing helper for the reset sequencing controller.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StHold,
        StStagger,
        StRun
    } rst_seq_state_e;

    localparam int unsigned DEF_NUM_DOMAINS    = 3;
    localparam int unsigned DEF_HOLD_CYCLES    = 8;
    localparam int unsigned DEF_STRETCH_CYCLES = 4;

    function automatic int unsigned cnt_width(int unsigned hold, int unsigned stretch);
        int unsigned max_val;
        max_val = (hold > stretch) ? hold : stretch;
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear and expiry compare against the hold or stretch limit.
module rst_seq_timer #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned HOLD_CYCLES    = 8,
    parameter int unsigned STRETCH_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    input  logic sel_stretch,
    output logic expired
);

    localparam logic [WIDTH-1:0] HoldLim    = WIDTH'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] StretchLim = WIDTH'(STRETCH_CYCLES - 1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    // Gated by en so a parked counter in RUN never reports expiry.
    assign expired = en && (cnt_q == (sel_stretch ? StretchLim : HoldLim));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them in order with a fixed gap.
// Optional completed-sequence counter port enabled by defining RST_SEQ_CNT_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   SYS_READY,
    output logic                   BUSY
`ifdef RST_SEQ_CNT_EN
    ,
    output logic [7:0]             RST_EVT_CNT
`endif
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STRETCH_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_DOMAINS) + 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 1) begin : g_bad_num_domains
        $fatal(1, "rst_seq_ctrl: NUM_DOMAINS must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "rst_seq_ctrl: HOLD_CYCLES must be >= 1");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $fatal(1, "rst_seq_ctrl: STRETCH_CYCLES must be >= 1");
    end

    rst_seq_state_e         state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] dom_rst_n_q;
    logic                   sys_ready_q;
    logic                   busy_q;
    logic                   expired;
    logic                   enter_run;

    rst_seq_timer #(
        .WIDTH          (CNT_W),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_timer (
        .CLK         (CLK),
        .RST         (RST),
        .clr         (SW_RST_REQ || expired),
        .en          (state_q != StRun),
        .sel_stretch (state_q == StStagger),
        .expired     (expired)
    );

    assign enter_run = !SW_RST_REQ && expired &&
                       (((state_q == StHold) && (NUM_DOMAINS == 1)) ||
                        ((state_q == StStagger) && (idx_q == LastIdx)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StHold;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            sys_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else if (SW_RST_REQ) begin
            state_q     <= StHold;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            sys_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (expired) begin
                        dom_rst_n_q <= NUM_DOMAINS'(1);
                        idx_q       <= IDX_W'(1);
                        state_q     <= (NUM_DOMAINS == 1) ? StRun : StStagger;
                    end
                end
                StStagger: begin
                    if (expired) begin
                        // OR-in keeps released bits a contiguous run from bit 0.
                        dom_rst_n_q <= dom_rst_n_q | (NUM_DOMAINS'(1) << idx_q);
                        idx_q       <= idx_q + IDX_W'(1);
                        if (idx_q == LastIdx) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    dom_rst_n_q <= '1;
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
            if (enter_run) begin
                sys_ready_q <= 1'b1;
                busy_q      <= 1'b0;
            end
        end
    end

`ifdef RST_SEQ_CNT_EN
    logic [7:0] evt_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            evt_cnt_q <= '0;
        end else if (enter_run && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_q <= evt_cnt_q + 8'd1;
        end
    end

    assign RST_EVT_CNT = evt_cnt_q;
`endif

    assign DOM_RST_N = dom_rst_n_q;
    assign SYS_READY = sys_ready_q;
    assign BUSY      = busy_q;

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencing controller that sits directly behind the two-flop reset synchronizer in each clock domain. It takes that domain's synchronized system reset and an optional software reset request, and drives a set of per-block active-low resets. Resets are held for a fixed time, then released one block at a time in a fixed order, with a programmable gap between releases. A single ready flag tells the system when every block is out of reset.

## Interface
- NUM_DOMAINS, 3: number of sequenced reset outputs; must be ≥1.
- HOLD_CYCLES, 8: cycles all outputs stay asserted after the reset is removed; must be ≥1.
- STRETCH_CYCLES, 4: cycles between consecutive domain releases; must be ≥1.
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-low reset, already synchronized on deassertion.
- SW_RST_REQ  input  1  level-sensitive software reset request, synchronous to CLK.
- DOM_RST_N  output  NUM_DOMAINS  per-domain active-low resets; bit 0 is released first.
- SYS_READY  output  1  high when all domains are released.
- BUSY  output  1  high while a sequence is in progress (states HOLD and STAGGER).
- RST_EVT_CNT  output  8  completed-sequence count; present only with RST_SEQ_CNT_EN.

## Operation
- States:
  - HOLD: all domains in reset, hold counter running.
  - STAGGER: releasing domains one by one.
  - RUN: all domains released.
- Registered state, counter, index (IDX) and outputs.
- While RST=0, asynchronously: state=HOLD, counter=0, IDX=0, DOM_RST_N=0, SYS_READY=0, BUSY=1, RST_EVT_CNT=0.
- HOLD:
  - The counter increments each cycle.
  - When counter==HOLD_CYCLES-1: set DOM_RST_N[0]=1, clear the counter, set IDX=1.
  - Next state is STAGGER, or RUN if NUM_DOMAINS==1.
- STAGGER:
  - The counter increments each cycle.
  - When counter==STRETCH_CYCLES-1: set DOM_RST_N[IDX]=1, clear the counter, increment IDX.
  - If IDX was NUM_DOMAINS-1, go to RUN on that same edge.
- RUN: SYS_READY=1, BUSY=0; all DOM_RST_N bits are 1.
- SW_RST_REQ=1 in any state, on the next edge:
  - DOM_RST_N=0, SYS_READY=0, BUSY=1, counter=0, IDX=0, state=HOLD.
  - This applies even mid-sequence: the sequence restarts from the beginning.
  - While SW_RST_REQ stays high, the counter is held at 0, so HOLD is stretched.
- SW_RST_REQ has priority over every counter-expiry transition.
- Once a domain is released, its DOM_RST_N bit stays high until RST or SW_RST_REQ.
- Released bits always form a contiguous run starting at bit 0.
- Counter width is clog2(max(HOLD_CYCLES, STRETCH_CYCLES))+1. IDX width is clog2(NUM_DOMAINS)+1. Neither wraps.

## Timing
- Edge 1 is the first rising CLK edge with RST=1 and SW_RST_REQ=0.
- DOM_RST_N[k] goes high after edge HOLD_CYCLES + k·STRETCH_CYCLES.
- SYS_READY rises, and BUSY falls, on the same edge as the last domain release.
- Defaults: bit 0 at edge 8, bit 1 at edge 12, bit 2 at edge 16; SYS_READY at edge 16.
- Software reset latency: outputs assert one edge after SW_RST_REQ is sampled high. The edge on which SW_RST_REQ is first sampled low counts as edge 1 of the new sequence.
- All outputs come directly from registers; no combinational paths from inputs to outputs.
- RST assertion is immediate (asynchronous) in any state and at any counter value.

## Configuration
- RST_SEQ_CNT_EN defined:
  - Adds the RST_EVT_CNT port.
  - The count increments on every entry into RUN and saturates at 255.
  - Only RST clears it; SW_RST_REQ does not.
- RST_SEQ_CNT_EN undefined: the port and its register are absent. Sequencing behaviour is identical.

## Structure
- Package rst_seq_pkg holds:
  - the state enum (HOLD, STAGGER, RUN);
  - the counter-width function;
  - the default parameter constants.
- One sub-module, rst_seq_timer:
  - a loadable up-counter with synchronous clear;
  - provides the expiry compare against a selected limit (HOLD_CYCLES or STRETCH_CYCLES);
  - shares CLK and RST with the parent.
- Parameter legality is checked at elaboration; an illegal parameter is a fatal elaboration error.

## Test plan
- Power-on with defaults: release RST → DOM_RST_N goes 001, 011, 111 at edges 8, 12, 16; SYS_READY=1 and BUSY=0 at edge 16.
- SW_RST_REQ one-cycle pulse in RUN → next edge DOM_RST_N=000, SYS_READY=0, BUSY=1; the release sequence repeats relative to the first low sample of the request.
- SW_RST_REQ asserted at edge 13 (bit 0 and bit 1 already released) → next edge DOM_RST_N=000; the sequence restarts from HOLD; no partial release persists.
- SW_RST_REQ held high for 20 cycles → all outputs stay low throughout; bit 0 releases HOLD_CYCLES edges after the request drops.
- RST asserted mid-STAGGER → all outputs go to their reset values immediately, with no clock edge; after RST is removed the timing is identical to power-on.
- NUM_DOMAINS=1, HOLD_CYCLES=1 with RST_SEQ_CNT_EN defined → DOM_RST_N and SYS_READY rise at edge 1; RST_EVT_CNT=1. After 300 software resets, RST_EVT_CNT=255.
